awp_shloop: RTL and testbench

AWP shift-loop sequencer: runs fixed-count mantissa shifts and normalize loops for the floating-point unit. Sits directly upstream of the FIC loop counter. It loads FIC with the iteration limit and decrements it once per shift. It consumes FIC's non-zero flag to decide when the loop ends. It also reports the number of shifts performed, for exponent correction.

---
 rtl/awp_shloop.sv | 110 +++++++++++
 tb/tb_awp_shloop.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/awp_shloop.sv
// AWP shift-loop sequencer: drives the FIC loop counter and the mantissa shifter
// for fixed-count shifts and normalize loops, and reports the shifts performed.
module awp_shloop (
  input  logic       clk_sys,
  input  logic       rab,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [5:0] cnt_in,
  input  logic       fic,
  input  logic       nrm,
  input  logic       zero,
  output logic       fic_load,
  output logic [5:0] fic_in,
  output logic       fic_cda,
  output logic       shr,
  output logic       shl,
  output logic       busy,
  output logic       done,
  output logic [5:0] shifts,
  output logic       zm,
  output logic       lim
);

  localparam int unsigned CntW = 6;

  localparam logic [1:0] OpFixR = 2'b00;
  localparam logic [1:0] OpNorm = 2'b10;
  localparam logic [1:0] OpNop  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   shifts_q;
  logic              zm_q;
  logic              lim_q;

  logic              norm_c;
  logic              step_c;
  logic              run_c;

  // One shift step happens in RUN unless a termination condition holds.
  always_comb begin
    norm_c = (op_q == OpNorm);
    run_c  = (state_q == S_RUN);
    step_c = 1'b0;
    if (run_c) begin
      if (norm_c) step_c = fic && !zero && !nrm;
      else        step_c = fic;
    end
  end

  // Strobes and status are forced low while reset is held, even mid-operation.
  assign fic_load = !rab && (state_q == S_LOAD);
  assign fic_cda  = !rab && step_c;
  assign shr      = !rab && step_c && (op_q == OpFixR);
  assign shl      = !rab && step_c && (op_q != OpFixR);
  assign busy     = !rab && (state_q != S_IDLE);
  assign done     = !rab && (state_q == S_DONE);
  assign fic_in   = rab ? CntW'(0) : cnt_q;
  assign shifts   = rab ? CntW'(0) : shifts_q;
  assign zm       = !rab && zm_q;
  assign lim      = !rab && lim_q;

  always_ff @(posedge clk_sys) begin
    if (rab) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      cnt_q    <= CntW'(0);
      shifts_q <= CntW'(0);
      zm_q     <= 1'b0;
      lim_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            cnt_q    <= cnt_in;
            shifts_q <= CntW'(0);
            zm_q     <= 1'b0;
            lim_q    <= 1'b0;
            state_q  <= (op == OpNop) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: state_q <= S_RUN;
        S_RUN: begin
          if (step_c) begin
            shifts_q <= shifts_q + CntW'(1);
          end else begin
            state_q <= S_DONE;
            // zero outranks nrm, nrm outranks the limit
            if (norm_c) begin
              if (zero)      zm_q  <= 1'b1;
              else if (!nrm) lim_q <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awp_shloop.sv
// Randomized scoreboard bench for awp_shloop with behavioural FIC and shifter models.
module tb_awp_shloop;

  localparam int NEVER = 1000;

  logic       clk_sys = 1'b0;
  logic       rab;
  logic       start;
  logic [1:0] op_i;
  logic [5:0] cnt_i;
  logic       fic, nrm, zero;
  logic       fic_load, fic_cda, shr, shl, busy, done, zm, lim;
  logic [5:0] fic_in, shifts;

  awp_shloop dut (
    .clk_sys(clk_sys), .rab(rab), .start(start), .op(op_i), .cnt_in(cnt_i),
    .fic(fic), .nrm(nrm), .zero(zero),
    .fic_load(fic_load), .fic_in(fic_in), .fic_cda(fic_cda),
    .shr(shr), .shl(shl), .busy(busy), .done(done),
    .shifts(shifts), .zm(zm), .lim(lim)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int t0, lat, shifts, zm, lim, nload, nshr, nshl;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  int   cyc = 0;

  // Environment: FIC counter and a shifter whose flags follow the shift count.
  logic [5:0] fic_cnt;
  int         shl_cnt;
  logic [1:0] noise;
  logic       nmode = 1'b0;
  int         nrm_after = NEVER;
  int         zero_after = NEVER;

  always @(posedge clk_sys) begin
    cyc   <= cyc + 1;
    noise <= 2'($urandom);
    if (rab)           fic_cnt <= 6'd0;
    else if (fic_load) fic_cnt <= fic_in;
    else if (fic_cda)  fic_cnt <= fic_cnt - 6'd1;
    if (fic_load)      shl_cnt <= 0;
    else if (shl)      shl_cnt <= shl_cnt + 1;
  end

  assign fic  = (fic_cnt != 6'd0);
  assign nrm  = nmode ? (shl_cnt >= nrm_after)  : noise[0];
  assign zero = nmode ? (shl_cnt >= zero_after) : noise[1];

  function automatic void check_eq(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: outcome decided by whichever event (zero, nrm, limit) comes first.
  function automatic exp_t model(logic [1:0] op, int cnt, int k, int j);
    exp_t e;
    e = '{default: 0};
    if (op == 2'b11) begin
      e.lat = 1;
    end else begin
      e.nload = 1;
      if (op == 2'b10) begin
        if (j <= k && j <= cnt) begin e.shifts = j; e.zm = 1; end
        else if (k <= cnt)      e.shifts = k;
        else begin e.shifts = cnt; e.lim = 1; end
        e.nshl = e.shifts;
      end else begin
        e.shifts = cnt;
        if (op == 2'b00) e.nshr = cnt; else e.nshl = cnt;
      end
      e.lat = e.shifts + 3;
    end
    return e;
  endfunction

  // Monitor: accumulate strobes per operation and score on each done pulse.
  int acc_load = 0, acc_shr = 0, acc_shl = 0, acc_cda = 0;
  always @(negedge clk_sys) begin
    exp_t e;
    if (rab) begin
      acc_load = 0; acc_shr = 0; acc_shl = 0; acc_cda = 0;
    end else begin
      check_eq("strobe_exclusive", int'((shr && shl) || (fic_cda && fic_load)), 0);
      acc_load += int'(fic_load);
      acc_shr  += int'(shr);
      acc_shl  += int'(shl);
      acc_cda  += int'(fic_cda);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("done_cycle", cyc - e.t0, e.lat);
          check_eq("shifts", int'(shifts), e.shifts);
          check_eq("zm", int'(zm), e.zm);
          check_eq("lim", int'(lim), e.lim);
          check_eq("fic_load_count", acc_load, e.nload);
          check_eq("shr_count", acc_shr, e.nshr);
          check_eq("shl_count", acc_shl, e.nshl);
          check_eq("fic_cda_count", acc_cda, e.nshr + e.nshl);
        end
        acc_load = 0; acc_shr = 0; acc_shl = 0; acc_cda = 0;
      end
    end
  end

  function automatic int all_outputs();
    return int'({fic_load, fic_cda, shr, shl, busy, done, zm, lim, fic_in, shifts});
  endfunction

  // Called at posedge+1 with the DUT idle; returns once done has been scored.
  task automatic run_txn(logic [1:0] op, int cnt, int k, int j, bit noisy);
    int n0;
    bit got;
    nmode      = (op == 2'b10);
    nrm_after  = k;
    zero_after = j;
    op_i  = op;
    cnt_i = 6'(cnt);
    start = 1'b1;
    begin
      exp_t e;
      e = model(op, cnt, k, j);
      e.t0 = cyc;
      sb.push_back(e);
    end
    n0  = n_done;
    got = 1'b0;
    @(posedge clk_sys); #1;
    for (int c = 0; c < 200; c++) begin
      if (n_done != n0) begin got = 1'b1; break; end
      if (busy && noisy) begin
        start = 1'($urandom);
        op_i  = 2'($urandom);
        cnt_i = 6'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk_sys); #1;
    end
    start = 1'b0;
    if (!got) begin
      check_eq("done_timeout", 0, 1);
      rab = 1'b1;
      @(posedge clk_sys); #1;
      rab = 1'b0;
      sb.delete();
    end
  endtask

  initial begin
    rab = 1'b1; start = 1'b0; op_i = 2'b00; cnt_i = 6'd0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_eq("reset_outputs", all_outputs(), 0);
    @(posedge clk_sys); #1;
    rab = 1'b0;
    @(negedge clk_sys);
    check_eq("post_reset_outputs", all_outputs(), 0);
    @(posedge clk_sys); #1;

    run_txn(2'b00, 5, NEVER, NEVER, 1'b0);
    run_txn(2'b01, 0, NEVER, NEVER, 1'b0);
    run_txn(2'b10, 39, 3, NEVER, 1'b0);
    run_txn(2'b10, 4, NEVER, NEVER, 1'b0);
    run_txn(2'b10, 4, NEVER, 0, 1'b0);
    run_txn(2'b11, 17, NEVER, NEVER, 1'b1);
    run_txn(2'b10, 5, 5, NEVER, 1'b1);
    run_txn(2'b10, 7, 2, 2, 1'b1);
    run_txn(2'b00, 63, NEVER, NEVER, 1'b1);

    // Reset in the middle of a fixed right shift after two strobes.
    nmode = 1'b0;
    op_i = 2'b00; cnt_i = 6'd10; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_eq("shifts_before_reset", int'(shifts), 2);
    @(posedge clk_sys); #1;
    rab = 1'b1;
    @(negedge clk_sys);
    check_eq("outputs_in_reset", all_outputs(), 0);
    @(posedge clk_sys); #1;
    rab = 1'b0;
    @(negedge clk_sys);
    check_eq("outputs_after_mid_reset", all_outputs(), 0);
    check_eq("fic_after_mid_reset", int'(fic), 0);
    @(posedge clk_sys); #1;
    run_txn(2'b00, 3, NEVER, NEVER, 1'b0);

    for (int i = 0; i < 50; i++) begin
      logic [1:0] rop;
      int rcnt, rk, rj;
      rop  = 2'($urandom);
      rcnt = int'($urandom_range(0, 63));
      rk   = int'($urandom_range(0, 70));
      rj   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : NEVER;
      run_txn(rop, rcnt, rk, rj, 1'($urandom));
    end

    repeat (3) @(posedge clk_sys);
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
